// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - shared constants, state type and parity helper for the PS/2 key event transmitter
package kbd_pkg;

    localparam logic [7:0] KBD_EXT_PREFIX   = 8'hE0;
    localparam logic [7:0] KBD_BREAK_PREFIX = 8'hF0;
    localparam int         PS2_FRAME_BITS   = 11;

    typedef enum logic [1:0] {
        IDLE,
        FRAME,
        GAP
    } kbd_tx_state_t;

    // PS/2 parity bit makes the total count of ones in data+parity odd
    function automatic logic ps2_odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_frame_serializer.sv
// rtl/ps2_frame_serializer.sv - turns one byte into an 11-cell PS/2 device-to-host frame
module ps2_frame_serializer
    import kbd_pkg::*;
#(
    parameter int CLK_DIV = 2000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       start,
    input  logic [7:0] txByte,
    output logic       busy,
    output logic       lastCell,
    output logic       ps2Clk,
    output logic       ps2Data
);

    localparam logic [15:0] DIV_LOAD = 16'(CLK_DIV - 1);
    localparam logic [3:0]  LAST_BIT = 4'(PS2_FRAME_BITS - 1);

    // Bits still to be sent after the start bit: data LSB first, parity, stop
    logic [PS2_FRAME_BITS-2:0] shift_q;
    logic [3:0]                bit_idx;
    logic                      phase;
    logic [15:0]               div_cnt;

    assign lastCell = busy && (bit_idx == LAST_BIT) && phase && (div_cnt == 16'd0);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            busy    <= 1'b0;
            shift_q <= '1;
            bit_idx <= 4'd0;
            phase   <= 1'b0;
            div_cnt <= 16'd0;
            ps2Clk  <= 1'b1;
            ps2Data <= 1'b1;
        end else if (start) begin
            busy    <= 1'b1;
            shift_q <= {1'b1, ps2_odd_parity(txByte), txByte};
            bit_idx <= 4'd0;
            phase   <= 1'b0;
            div_cnt <= DIV_LOAD;
            ps2Clk  <= 1'b1;
            ps2Data <= 1'b0;
        end else if (busy) begin
            if (div_cnt != 16'd0) begin
                div_cnt <= div_cnt - 16'd1;
            end else begin
                div_cnt <= DIV_LOAD;
                if (!phase) begin
                    phase  <= 1'b1;
                    ps2Clk <= 1'b0;
                end else begin
                    // Data only moves while the clock returns high
                    phase  <= 1'b0;
                    ps2Clk <= 1'b1;
                    if (bit_idx == LAST_BIT) begin
                        busy    <= 1'b0;
                        ps2Data <= 1'b1;
                    end else begin
                        bit_idx <= bit_idx + 4'd1;
                        shift_q <= shift_q >> 1;
                        ps2Data <= shift_q[0];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/kbd_event_transmitter.sv
// rtl/kbd_event_transmitter.sv - sequences E0/F0/code bytes of a key event onto the PS/2 serializer
module kbd_event_transmitter
    import kbd_pkg::*;
#(
    parameter int CLK_DIV    = 2000,
    parameter int GAP_CYCLES = 4000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [8:0] keyCode,
    input  logic       make,
    input  logic       brakee,
    output logic       ready,
    output logic       ps2Clk,
    output logic       ps2Data,
    output logic       donePulse,
    output logic       dropPulse
);

    localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES - 1);

    kbd_tx_state_t state_q;
    logic [7:0]    code_q;
    logic          pend_f0;
    logic          pend_code;
    logic [15:0]   gap_cnt;

    logic          accept;
    logic          reject;
    logic          gap_end;
    logic          ser_start;
    logic          ser_busy;
    logic          ser_last;
    logic [7:0]    next_byte;

    always_comb begin
        accept    = ready && (make ^ brakee);
        reject    = (ready && make && brakee) || (!ready && (make || brakee));
        gap_end   = (state_q == GAP) && (gap_cnt == 16'd0);
        ser_start = (accept || gap_end) && !ser_busy;
        next_byte = code_q;
        if (state_q == IDLE) begin
            next_byte = keyCode[8] ? KBD_EXT_PREFIX :
                        (brakee ? KBD_BREAK_PREFIX : keyCode[7:0]);
        end else if (pend_f0) begin
            next_byte = KBD_BREAK_PREFIX;
        end
    end

    ps2_frame_serializer #(
        .CLK_DIV (CLK_DIV)
    ) u_serializer (
        .clk      (clk),
        .resetN   (resetN),
        .start    (ser_start),
        .txByte   (next_byte),
        .busy     (ser_busy),
        .lastCell (ser_last),
        .ps2Clk   (ps2Clk),
        .ps2Data  (ps2Data)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= IDLE;
            code_q    <= 8'd0;
            pend_f0   <= 1'b0;
            pend_code <= 1'b0;
            gap_cnt   <= 16'd0;
            ready     <= 1'b1;
            donePulse <= 1'b0;
            dropPulse <= 1'b0;
        end else begin
            donePulse <= 1'b0;
            dropPulse <= reject;
            case (state_q)
                IDLE: begin
                    if (ser_start) begin
                        // Remember which bytes still follow the one just started
                        state_q   <= FRAME;
                        ready     <= 1'b0;
                        code_q    <= keyCode[7:0];
                        pend_f0   <= keyCode[8] && brakee;
                        pend_code <= keyCode[8] || brakee;
                    end
                end
                FRAME: begin
                    if (ser_last) begin
                        if (pend_f0 || pend_code) begin
                            state_q <= GAP;
                            gap_cnt <= GAP_LOAD;
                        end else begin
                            state_q   <= IDLE;
                            ready     <= 1'b1;
                            donePulse <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt != 16'd0) begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end else if (ser_start) begin
                        state_q <= FRAME;
                        if (pend_f0) begin
                            pend_f0 <= 1'b0;
                        end else begin
                            pend_code <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kbd_event_transmitter.sv
// tb/tb_kbd_event_transmitter.sv - scoreboard bench for kbd_event_transmitter with a PS/2 line decoder
module tb_kbd_event_transmitter;

    localparam int D = 4;
    localparam int G = 8;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic [8:0] keyCode = 9'd0;
    logic       make = 1'b0;
    logic       brakee = 1'b0;
    logic       ready;
    logic       ps2Clk;
    logic       ps2Data;
    logic       donePulse;
    logic       dropPulse;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int last_done = 0;

    typedef struct {
        logic [7:0] b;
        int         t;
    } exp_frame_t;

    exp_frame_t fq[$];
    int         dq[$];
    int         xq[$];

    kbd_event_transmitter #(
        .CLK_DIV    (D),
        .GAP_CYCLES (G)
    ) dut (
        .clk       (clk),
        .resetN    (resetN),
        .keyCode   (keyCode),
        .make      (make),
        .brakee    (brakee),
        .ready     (ready),
        .ps2Clk    (ps2Clk),
        .ps2Data   (ps2Data),
        .donePulse (donePulse),
        .dropPulse (dropPulse)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint got, input longint want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h at cycle %0d", name, got, want, cyc);
        end
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic par;
        par = (($countones(b) % 2) == 0);
        return {1'b1, par, b, 1'b0};
    endfunction

    // Reference model: decides accept/drop from the request time alone and
    // predicts every frame start, the done cycle and drop cycle.
    task automatic present(input logic mk, input logic br, input logic [8:0] code);
        int         c0;
        int         a;
        logic [7:0] seq[$];
        c0      = cyc;
        a       = c0 + 1;
        make    = mk;
        brakee  = br;
        keyCode = code;
        if (mk || br) begin
            if (c0 >= last_done && (mk ^ br)) begin
                if (code[8]) seq.push_back(8'hE0);
                if (br)      seq.push_back(8'hF0);
                seq.push_back(code[7:0]);
                foreach (seq[j]) fq.push_back('{seq[j], a + j * (22 * D + G)});
                last_done = a + seq.size() * 22 * D + (seq.size() - 1) * G;
                dq.push_back(last_done);
            end else begin
                xq.push_back(a);
            end
        end
        @(negedge clk);
        make   = 1'b0;
        brakee = 1'b0;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic monitor();
        bit          in_frame = 1'b0;
        bit          tim_ok = 1'b1;
        int          nbits = 0;
        int          fstart = 0;
        logic [10:0] got = '0;
        logic        pc = 1'b1;
        logic        pd = 1'b1;
        exp_frame_t  e;
        forever begin
            @(negedge clk);
            if (!resetN) begin
                in_frame = 1'b0;
                pc = 1'b1;
                pd = 1'b1;
            end else begin
                if (!in_frame && pd && !ps2Data) begin
                    in_frame = 1'b1;
                    fstart   = cyc;
                    nbits    = 0;
                    tim_ok   = 1'b1;
                end
                if (in_frame && pc && !ps2Clk) begin
                    got[nbits] = ps2Data;
                    if (cyc != fstart + 2 * D * nbits + D) tim_ok = 1'b0;
                    nbits++;
                    if (nbits == 11) begin
                        in_frame = 1'b0;
                        chk("frame_expected", fq.size() > 0, 1);
                        if (fq.size() > 0) begin
                            e = fq.pop_front();
                            chk("frame_bits", got, frame_of(e.b));
                            chk("frame_start", fstart, e.t);
                            chk("cell_timing", tim_ok, 1);
                        end
                    end
                end
                if (donePulse) begin
                    chk("done_expected", dq.size() > 0, 1);
                    if (dq.size() > 0) chk("done_cycle", cyc, dq.pop_front());
                end
                if (dropPulse) begin
                    chk("drop_expected", xq.size() > 0, 1);
                    if (xq.size() > 0) chk("drop_cycle", cyc, xq.pop_front());
                end
                pc = ps2Clk;
                pd = ps2Data;
            end
        end
    endtask

    initial begin
        int a;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        chk("reset_outputs", {ready, ps2Clk, ps2Data, donePulse, dropPulse}, 5'b11100);
        resetN = 1'b1;
        @(negedge clk);
        chk("post_reset_outputs", {ready, ps2Clk, ps2Data, donePulse, dropPulse}, 5'b11100);

        present(1'b1, 1'b0, 9'h029); wait_until(last_done);
        present(1'b0, 1'b1, 9'h029); wait_until(last_done);
        present(1'b1, 1'b0, 9'h175); wait_until(last_done);
        present(1'b0, 1'b1, 9'h175); wait_until(last_done);
        present(1'b1, 1'b1, 9'h029); repeat (30) @(negedge clk);
        present(1'b1, 1'b0, 9'h029);
        repeat (20) @(negedge clk);
        present(1'b0, 1'b1, 9'h155);
        repeat (9) @(negedge clk);
        present(1'b1, 1'b1, 9'h0AA);
        wait_until(last_done);
        present(1'b1, 1'b0, 9'h11C);
        wait_until(last_done);

        // Asynchronous reset in the low half of cell 5 of the F0 frame
        present(1'b0, 1'b1, 9'h029);
        a = cyc;
        wait_until(a + 45);
        #1 resetN = 1'b0;
        #1 chk("midreset_outputs", {ready, ps2Clk, ps2Data, donePulse}, 4'b1110);
        fq.delete();
        dq.delete();
        xq.delete();
        last_done = 0;
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        present(1'b1, 1'b0, 9'h029);
        wait_until(last_done);

        for (int i = 0; i < 40; i++) begin
            int   kind;
            int   mode;
            logic [8:0] code;
            kind = $urandom_range(0, 9);
            mode = $urandom_range(0, 3);
            code = 9'($urandom);
            if (mode == 0)      wait_until(last_done);
            else if (mode == 1) repeat ($urandom_range(0, 60)) @(negedge clk);
            else                wait_until(last_done + $urandom_range(0, 5));
            if (kind == 0)      present(1'b1, 1'b1, code);
            else if (kind < 6)  present(1'b1, 1'b0, code);
            else                present(1'b0, 1'b1, code);
        end

        wait_until(last_done);
        repeat (4) @(negedge clk);
        chk("frames_left", fq.size(), 0);
        chk("dones_left", dq.size(), 0);
        chk("drops_left", xq.size(), 0);
        chk("idle_lines", {ready, ps2Clk, ps2Data}, 3'b111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/kbd_event_transmitter.md
# kbd_event_transmitter

Serializes keyboard key events into a PS/2 device-to-host byte stream, the inverse of the keyboard receive path that delivers `keyCode`/`make`/`brakee` to the key decoders. An event is one 9-bit key code plus a make or break strobe. The block emits the standard scancode sequence: optional `E0` prefix, optional `F0` break prefix, then the low code byte. Each byte is an 11-bit PS/2 frame on `ps2Clk`/`ps2Data`. It is used as a keyboard emulator for loopback tests of the receive chain and for board self-test.

## Interface
- `CLK_DIV`, 2000: system clocks per PS/2 clock half-period; legal range 1..65535.
- `GAP_CYCLES`, 4000: idle clocks, both lines high, between consecutive bytes of one event; legal range 1..65535.
- `clk` in 1: system clock.
- `resetN` in 1: reset. Asynchronous and active-low; one clock domain only.
- `keyCode` in 9: bit 8 = extended (E0) key, bits 7:0 = code byte.
- `make` in 1: press request strobe.
- `brakee` in 1: release request strobe.
- `ready` out 1: high when a new event can be accepted.
- `ps2Clk` out 1: PS/2 clock, idle high.
- `ps2Data` out 1: PS/2 data, idle high.
- `donePulse` out 1: one-cycle pulse when the last frame of an event completes.
- `dropPulse` out 1: one-cycle pulse when a request is rejected.

## Operation
- Reset values: `ready`=1, `ps2Clk`=1, `ps2Data`=1, `donePulse`=0, `dropPulse`=0.
- **Accept.** A request is accepted on a rising edge where `ready`=1 and exactly one of `make`/`brakee` is 1. `keyCode` is captured on that edge.
- **Reject.** `dropPulse` is asserted for 1 cycle, and nothing is sent, in two cases:
  - `make`=`brakee`=1 while `ready`=1;
  - any strobe while `ready`=0.
  - In both cases the event in flight is unaffected.
- **Byte sequence** (1 to 3 bytes):
  - `E0`, if `keyCode[8]`=1;
  - then `F0`, if the request was a break;
  - then `keyCode[7:0]`.
- **Frame format:** start bit 0, data bits 0..7 (LSB first), odd parity = XNOR-reduce of the data, stop bit 1. This is 11 bit cells.
- **Bit cell:** 2·`CLK_DIV` cycles. `ps2Data` is driven with the cell value for the whole cell. `ps2Clk`=1 for the first `CLK_DIV` cycles and 0 for the last `CLK_DIV` cycles. Data therefore changes only while the clock is high, and the host samples on the falling edge.
- **FSM states:**
  - IDLE: `ready`=1, lines high.
  - FRAME: bit-cell sequencing, using bit index 0..10, phase flag and divider counter.
  - GAP: lines high for `GAP_CYCLES`.
- **Transitions:**
  - IDLE→FRAME on accept.
  - FRAME→GAP at the end of cell 10 if bytes remain.
  - GAP→FRAME after `GAP_CYCLES`.
  - FRAME→IDLE at the end of cell 10 of the last byte.
- **Asynchronous reset mid-event:** outputs return to their reset values immediately, the event is discarded, and no `donePulse` is issued.

## Timing
- Accept edge k:
  - from cycle k+1: `ready`=0, `ps2Data`=0 (start bit), `ps2Clk`=1.
- Cell i of a frame starting at cycle s occupies cycles s+2·`CLK_DIV`·i through s+2·`CLK_DIV`·(i+1)−1.
- **Single-byte event:** `donePulse`=1 and `ready`=1 in cycle k+1+22·`CLK_DIV`. A new request can be accepted on that same edge.
- **Multi-byte event:** each additional byte adds 22·`CLK_DIV`+`GAP_CYCLES` cycles. There is no trailing gap after the last byte.
- `ps2Clk` and `ps2Data` are registered outputs; no combinational path from any input.
- Divider and gap counters are 16 bits and wrap only by reload, never by overflow.

## Structure
- Shared package `kbd_pkg`:
  - `KBD_EXT_PREFIX`=8'hE0;
  - `KBD_BREAK_PREFIX`=8'hF0;
  - `PS2_FRAME_BITS`=11;
  - state enum `kbd_tx_state_t` {IDLE, FRAME, GAP}.
- Sub-module `ps2_frame_serializer`:
  - function: one 8-bit byte → one 11-cell frame, parameter `CLK_DIV`;
  - ports: start/byte in, busy/lastCell out, `ps2Clk`/`ps2Data` out.
- Top level: event capture, byte-sequence FSM, gap timer, pulses.

## Test plan
Run with `CLK_DIV`=4 and `GAP_CYCLES`=8.
- **Make, plain key.** `keyCode`=9'h029 with `make`=1 → one frame with data 8'h29 and parity 0; `donePulse` 89 cycles after accept.
- **Break, plain key.** `keyCode`=9'h029 with `brakee`=1 → frames F0 (parity 1), gap of 8, then 29 (parity 0); `donePulse` at accept+1+88+8+88.
- **Extended make.** `keyCode`=9'h175 with `make`=1 → frames E0 (parity 0), then 75 (parity 0).
- **Extended break.** `keyCode`=9'h175 with `brakee`=1 → frames E0, F0, 75 with two 8-cycle gaps; exactly one `donePulse`.
- **Rejected requests.** Both strobes high in IDLE → `dropPulse`, lines stay idle. A strobe mid-frame → `dropPulse`, and the frame in flight is bit-identical to an undisturbed run.
- **Reset mid-event.** `resetN` low during cell 5 of the F0 frame → `ps2Clk`=`ps2Data`=1 and `ready`=1 immediately, no `donePulse`. A following 9'h029 make transmits normally.
